// File: rtl/llc_pkg.sv
// Constants shared with the LLC, a line-address helper and the read-arbiter state encoding.
package llc_pkg;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned OFFSET_W   = $clog2(LINE_BYTES);
    localparam int unsigned DATA_W     = LINE_BYTES * 8;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;

endpackage

// File: rtl/llc_read_arbiter_rr_priority_pick.sv
// Round-robin first-set search: returns the first set bit of req at or above start, wrapping.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, start} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                pos = pos - (IDX_W + 1)'(NUM_REQ);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/llc_read_arbiter.sv
// Round-robin arbiter sharing the LLC secondary read port; hit lines are returned to the
// winner and to every pending requester of the same line in a single response pulse.
module llc_read_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_W     = llc_pkg::ADDR_W,
    parameter int unsigned LINE_BYTES = llc_pkg::LINE_BYTES,
    parameter int unsigned DATA_W     = LINE_BYTES * 8,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         llc_r_addr,
    output logic                      llc_r_addr_valid,
    input  logic [DATA_W-1:0]         llc_r_data,
    input  logic                      llc_r_data_valid,
    output logic                      timeout_err,
    output logic                      busy
);

    import llc_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    arb_state_e          state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    grant_idx_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [ADDR_W-1:0]   llc_r_addr_q;
    logic                llc_r_addr_valid_q;
    logic                timeout_err_q;
    logic                busy_q;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic [ADDR_W-1:0]   pick_addr;
    logic [NUM_REQ-1:0]  serve_mask;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign pick_addr = req_addr[pick_idx * ADDR_W +: ADDR_W];

    // Coalesce: everyone still waiting on the granted line is served by the same hit.
    always_comb begin
        serve_mask = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j] && ((req_addr[j * ADDR_W +: ADDR_W] & LINE_MASK) == llc_r_addr_q)) begin
                serve_mask[j] = 1'b1;
            end
        end
        serve_mask[grant_idx_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            rr_ptr_q           <= '0;
            grant_idx_q        <= '0;
            wait_cnt_q         <= '0;
            rsp_valid_q        <= '0;
            rsp_data_q         <= '0;
            llc_r_addr_q       <= '0;
            llc_r_addr_valid_q <= 1'b0;
            timeout_err_q      <= 1'b0;
            busy_q             <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx_q        <= pick_idx;
                        llc_r_addr_q       <= pick_addr & LINE_MASK;
                        llc_r_addr_valid_q <= 1'b1;
                        busy_q             <= 1'b1;
                        wait_cnt_q         <= '0;
                        rr_ptr_q           <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                               : pick_idx + 1'b1;
                        state_q            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (llc_r_data_valid) begin
                        rsp_data_q         <= llc_r_data;
                        rsp_valid_q        <= serve_mask;
                        llc_r_addr_valid_q <= 1'b0;
                        state_q            <= RESP;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        timeout_err_q <= 1'b1;
                    end
                    // Saturate so a hung grant never wraps the counter.
                    if (wait_cnt_q != CNT_LAST) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    wait_cnt_q  <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign llc_r_addr       = llc_r_addr_q;
    assign llc_r_addr_valid = llc_r_addr_valid_q;
    assign timeout_err      = timeout_err_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_llc_read_arbiter.sv
// Bench for llc_read_arbiter: vector table, hand-written sequences and a response scoreboard.
module tb_llc_read_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 512;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   llc_r_addr;
    logic            llc_r_addr_valid;
    logic [DW-1:0]   llc_r_data;
    logic            llc_r_data_valid;
    logic            timeout_err;
    logic            busy;

    logic [N-1:0]    t_req_valid;
    logic [N*AW-1:0] t_req_addr;
    logic [N-1:0]    t_rsp_valid;
    logic [DW-1:0]   t_rsp_data;
    logic [AW-1:0]   t_llc_r_addr;
    logic            t_llc_r_addr_valid;
    logic [DW-1:0]   t_llc_r_data;
    logic            t_llc_r_data_valid;
    logic            t_timeout_err;
    logic            t_busy;

    int hit_delay;
    int issue_cnt;
    int errors;
    int checks;

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [AW-1:0] line;
    } exp_t;

    typedef struct {
        logic [N-1:0]    rv;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    mask;
        logic [AW-1:0]   line;
        int              delay;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vec[6];

    llc_read_arbiter #(
        .NUM_REQ (N)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .llc_r_addr       (llc_r_addr),
        .llc_r_addr_valid (llc_r_addr_valid),
        .llc_r_data       (llc_r_data),
        .llc_r_data_valid (llc_r_data_valid),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    llc_read_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (16)
    ) u_to (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (t_req_valid),
        .req_addr         (t_req_addr),
        .rsp_valid        (t_rsp_valid),
        .rsp_data         (t_rsp_data),
        .llc_r_addr       (t_llc_r_addr),
        .llc_r_addr_valid (t_llc_r_addr_valid),
        .llc_r_data       (t_llc_r_data),
        .llc_r_data_valid (t_llc_r_data_valid),
        .timeout_err      (t_timeout_err),
        .busy             (t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) begin
            d[i*64 +: 64] = a ^ (64'h0123_4567_89AB_CDEF * (i + 1));
        end
        return d;
    endfunction

    // LLC model: hits once the current address has been presented for hit_delay cycles.
    assign llc_r_data       = line_data(llc_r_addr);
    assign llc_r_data_valid = llc_r_addr_valid && (issue_cnt >= hit_delay);

    always @(posedge clk) issue_cnt <= llc_r_addr_valid ? issue_cnt + 1 : 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_rsp(input logic [N-1:0] m, input logic [AW-1:0] l);
        exp_t e;
        e.mask = m;
        e.line = l;
        sb.push_back(e);
    endtask

    // Requesters drop req_valid as soon as their pulse is seen.
    task automatic tick();
        @(negedge clk);
        req_valid   = req_valid & ~rsp_valid;
        t_req_valid = t_req_valid & ~t_rsp_valid;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (rsp_valid == '0 && n < max) begin
            tick();
            n++;
        end
        chk("rsp_seen", rsp_valid != '0, 1);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", rsp_valid, '0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_mask", rsp_valid, mon_e.mask);
                chk("rsp_data", rsp_data, line_data(mon_e.line));
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && llc_r_addr_valid) begin
            assert (req_valid[u_dut.grant_idx_q])
            else $error("protocol: granted requester dropped req_valid during issue");
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        errors       = 0;
        checks       = 0;
        hit_delay    = 0;
        reset        = 1'b1;
        req_valid    = '0;
        req_addr     = '0;
        t_req_valid  = '0;
        t_req_addr   = '0;
        t_llc_r_data = '0;
        t_llc_r_data_valid = 1'b0;

        vec[0] = '{3'b001, {64'h0, 64'h0, 64'h1040}, 3'b001, 64'h1040, 0};
        vec[1] = '{3'b010, {64'h0, 64'h2000, 64'h0}, 3'b010, 64'h2000, 40};
        vec[2] = '{3'b101, {64'h3030, 64'h0, 64'h3008}, 3'b101, 64'h3000, 0};
        vec[3] = '{3'b100, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0}, 3'b100,
                   64'hFFFF_FFFF_FFFF_FFC0, 2};
        vec[4] = '{3'b111, {64'h7F, 64'h55, 64'h40}, 3'b111, 64'h40, 1};
        vec[5] = '{3'b011, {64'h0, 64'h1234_5678_9ABC_DEC1, 64'h1234_5678_9ABC_DEF0}, 3'b011,
                   64'h1234_5678_9ABC_DEC0, 0};

        tick();
        tick();
        chk("reset_rsp_valid", rsp_valid, '0);
        chk("reset_rsp_data", rsp_data, '0);
        chk("reset_addr", llc_r_addr, '0);
        chk("reset_addr_valid", llc_r_addr_valid, 0);
        chk("reset_timeout", timeout_err, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            tick();
            chk("no_reissue", llc_r_addr_valid, 0);
            hit_delay = vec[v].delay;
            req_addr  = vec[v].addr;
            req_valid = vec[v].rv;
            expect_rsp(vec[v].mask, vec[v].line);
            tick();
            chk("vec_addr_valid", llc_r_addr_valid, 1);
            chk("vec_llc_addr", llc_r_addr, vec[v].line);
            chk("vec_busy", busy, 1);
            wait_rsp(vec[v].delay + 20, n);
            chk("vec_latency", n, vec[v].delay + 1);
            tick();
            chk("vec_rsp_clear", rsp_valid, '0);
            chk("vec_busy_clear", busy, 0);
            chk("vec_addr_valid_low", llc_r_addr_valid, 0);
            chk("vec_no_timeout", timeout_err, 0);
        end

        // Contention from rr_ptr=0, requester 0 comes back for another line.
        reset_dut();
        hit_delay = 0;
        req_addr  = {64'h30000, 64'h20000, 64'h10000};
        req_valid = 3'b111;
        expect_rsp(3'b001, 64'h10000);
        expect_rsp(3'b010, 64'h20000);
        expect_rsp(3'b100, 64'h30000);
        wait_rsp(10, n);
        chk("rr_first_latency", n, 2);
        tick();
        tick();
        req_addr[0 +: 64] = 64'h40000;
        req_valid[0]      = 1'b1;
        expect_rsp(3'b001, 64'h40000);
        wait_rsp(10, n);
        chk("rr_second_latency", n, 1);
        tick();
        wait_rsp(10, n);
        chk("rr_third_latency", n, 2);
        tick();
        wait_rsp(10, n);
        chk("rr_fourth_latency", n, 2);
        tick();
        chk("rr_done_busy", busy, 0);

        // Reset in the middle of an outstanding grant.
        tick();
        hit_delay         = 1000;
        req_addr[64 +: 64] = 64'h5000;
        req_valid         = 3'b010;
        tick();
        tick();
        tick();
        chk("pre_reset_issue", llc_r_addr_valid, 1);
        reset = 1'b1;
        tick();
        chk("mid_reset_rsp_valid", rsp_valid, '0);
        chk("mid_reset_rsp_data", rsp_data, '0);
        chk("mid_reset_addr", llc_r_addr, '0);
        chk("mid_reset_addr_valid", llc_r_addr_valid, 0);
        chk("mid_reset_busy", busy, 0);
        reset     = 1'b0;
        hit_delay = 0;
        expect_rsp(3'b010, 64'h5000);
        tick();
        chk("reissue_valid", llc_r_addr_valid, 1);
        chk("reissue_addr", llc_r_addr, 64'h5000);
        wait_rsp(10, n);
        chk("reissue_latency", n, 1);
        tick();

        // Timeout on the TIMEOUT=16 instance whose LLC never hits.
        reset_dut();
        chk("to_reset", t_timeout_err, 0);
        t_req_addr  = {64'h0, 64'h0, 64'h7000};
        t_req_valid = 3'b001;
        for (int i = 0; i < 16; i++) tick();
        chk("to_before", t_timeout_err, 0);
        chk("to_issue_addr", t_llc_r_addr, 64'h7000);
        tick();
        chk("to_rise", t_timeout_err, 1);
        chk("to_busy", t_busy, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("to_sticky", t_timeout_err, 1);
        chk("to_still_issue", t_llc_r_addr_valid, 1);
        chk("to_no_rsp", t_rsp_valid, '0);
        chk("main_no_timeout", timeout_err, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/llc_read_arbiter.md
Name: llc_read_arbiter

Overview:
- Shares the LLC's single secondary read port (S2_R_ADDR / S2_R_ADDR_VALID / S2_R_DATA / S2_R_DATA_VALID) between NUM_REQ line-read requesters, e.g. I-cache refill, D-cache refill and page-table walker.
- Grants are round-robin. Each grant is held until the LLC reports a hit.
- The hit line is registered and returned to the winner, and to any other pending requester asking for the same line, as a one-cycle response pulse.
- Sits between the L1/PTW miss logic and the LLC; the LLC's own miss handling (AXI refill/evict) is invisible to this block.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 64, address width
- LINE_BYTES, 64, line size in bytes; OFFSET_W = $clog2(LINE_BYTES)
- DATA_W, 512, line width in bits (LINE_BYTES*8)
- TIMEOUT, 4096, cycles a grant may wait for a hit before the error flag is set

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester read request; held high until that requester's rsp_valid bit
- req_addr  in  NUM_REQ*ADDR_W  packed request addresses, requester i at [i*ADDR_W +: ADDR_W]; stable while req_valid
- rsp_valid  out  NUM_REQ  one-cycle pulse per served requester
- rsp_data  out  DATA_W  line data, valid while any rsp_valid bit is set
- llc_r_addr  out  ADDR_W  to LLC S2_R_ADDR
- llc_r_addr_valid  out  1  to LLC S2_R_ADDR_VALID
- llc_r_data  in  DATA_W  from LLC S2_R_DATA
- llc_r_data_valid  in  1  from LLC S2_R_DATA_VALID; combinational hit for the current llc_r_addr
- timeout_err  out  1  sticky; set when a grant exceeds TIMEOUT cycles
- busy  out  1  high in ISSUE or RESP

Behaviour:
- Reset (synchronous, active-high, overrides all else, including mid-transaction): state=IDLE; rr_ptr=0; grant_idx=0; wait_cnt=0; rsp_valid=0; rsp_data=0; llc_r_addr=0; llc_r_addr_valid=0; timeout_err=0; busy=0. Any in-flight grant is dropped; requesters keep req_valid high and are re-arbitrated after reset.
- All outputs come from registers or state decode; there is no combinational path from req_* to llc_r_*.
- FSM IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0.
  - Register grant_idx and the line-aligned address (req_addr with low OFFSET_W bits zeroed) into llc_r_addr.
  - Go to ISSUE. rr_ptr = grant_idx+1, wrapping to 0 at NUM_REQ.
- FSM ISSUE:
  - llc_r_addr_valid=1 and wait_cnt increments each cycle.
  - When llc_r_data_valid=1: latch llc_r_data into rsp_data and compute the serve mask (below); go to RESP.
  - If wait_cnt reaches TIMEOUT-1 with no hit: set timeout_err and stay in ISSUE (no abort).
- FSM RESP:
  - rsp_valid = serve mask for exactly one cycle; llc_r_addr_valid=0; wait_cnt=0; go to IDLE.
- Serve mask: the granted bit, plus every requester j with req_valid[j]=1 whose line address equals the granted line address.
- Coalesced requesters are served in the same pulse and are not re-issued. rr_ptr does not move for them.
- A requester that was just served cannot be re-granted before the next cycle's IDLE evaluation; it must drop req_valid the cycle after its pulse.
- Latency: request with idle arbiter in cycle 0 -> llc_r_addr_valid in cycle 1 -> on immediate hit, rsp_valid in cycle 2. Minimum request-to-request spacing is 3 cycles.
- A req_valid drop by the granted requester during ISSUE is a protocol violation; behaviour is undefined and the bench asserts it never happens.
- Simultaneous requests: strict round-robin, no starvation. Worst-case wait is NUM_REQ-1 grants.
- timeout_err is cleared only by reset.

Decomposition:
- Shared package llc_pkg holds:
  - LINE_BYTES, OFFSET_W, DATA_W, ADDR_W constants, shared with the LLC.
  - a line_addr() function that zeroes the offset bits.
  - the arbiter state enum {IDLE, ISSUE, RESP}.
- One natural sub-module, rr_priority_pick: combinational round-robin first-set search over a NUM_REQ-bit vector from a start pointer. It returns the index and a found flag.

Test Plan:
- Single request, req 0 at 0x1040, LLC hits immediately -> llc_r_addr=0x1040 in cycle 1; rsp_valid=3'b001 in cycle 2; rsp_data equals the LLC line.
- Miss then hit: req 1 at 0x2000, llc_r_data_valid held low for 40 cycles -> llc_r_addr_valid stays high 40+ cycles; rsp_valid=3'b010 one cycle after the hit; timeout_err=0.
- Contention: all three requesters valid with distinct lines, rr_ptr=0 -> grants in order 0,1,2. With req 0 re-raised after its pulse, order continues 0,1,2,0.
- Coalescing: req 0 at 0x3008 and req 2 at 0x3030 (same line 0x3000) -> one LLC access to 0x3000; rsp_valid=3'b101 in one pulse.
- Timeout: TIMEOUT=16, LLC never hits -> timeout_err rises after 16 ISSUE cycles and stays high; busy=1.
- Reset mid-ISSUE -> next cycle all outputs 0 and state IDLE; with req still valid, re-issue occurs in the following cycle.
